// File: rtl/register_file_r_en.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_r_en
//  Purpose  : DEPTH x WIDTH register bank with global enable, asynchronous
//             clear, one write port, two registered write-first read ports,
//             a streaming shift mode and per-entry valid tracking.
//  Revision : 1.0  initial release
// ============================================================================
module register_file_r_en #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             flush,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] shift_in,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr0,
  output logic [WIDTH-1:0] rd_data0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] shift_out,
  output logic [DEPTH-1:0] valid_vec,
  output logic [AW:0]      valid_cnt,
  output logic             err
);

  // Storage and registered outputs
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q,     valid_d;
  logic [WIDTH-1:0] rd_data0_q,  rd_data0_d;
  logic [WIDTH-1:0] rd_data1_q,  rd_data1_d;
  logic [WIDTH-1:0] shift_out_q, shift_out_d;
  logic [AW:0]      valid_cnt_q, valid_cnt_d;
  logic             err_q,       err_d;

  // Address-decode hit flags (an address >= DEPTH never hits)
  logic wr_hit;
  logic rd_hit0;
  logic rd_hit1;

  // Next bank contents and valid bits: flush > shift > write, all gated by en
  always_comb begin
    mem_d       = mem_q;
    valid_d     = valid_q;
    shift_out_d = shift_out_q;
    wr_hit      = 1'b0;
    if (en) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_d[i] = '0;
        end
        valid_d = '0;
      end else if (shift_en) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          mem_d[i] = mem_q[i-1];
        end
        mem_d[0]    = shift_in;
        valid_d     = {valid_q[DEPTH-2:0], 1'b1};
        shift_out_d = mem_q[DEPTH-1];
      end else if (wr_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_addr == AW'(i)) begin
            mem_d[i]   = wr_data;
            valid_d[i] = 1'b1;
            wr_hit     = 1'b1;
          end
        end
      end
    end
  end

  // Read ports sample the post-update bank, which gives write-first bypass
  // and post-shift data without a separate forwarding path
  always_comb begin
    rd_data0_d = rd_data0_q;
    rd_data1_d = rd_data1_q;
    rd_hit0    = 1'b0;
    rd_hit1    = 1'b0;
    if (en) begin
      rd_data0_d = '0;
      rd_data1_d = '0;
      if (!flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_addr0 == AW'(i)) begin
            rd_data0_d = mem_d[i];
            rd_hit0    = 1'b1;
          end
          if (rd_addr1 == AW'(i)) begin
            rd_data1_d = mem_d[i];
            rd_hit1    = 1'b1;
          end
        end
      end
    end
  end

  // Error pulse: dropped write under shift, out-of-range write or read.
  // A flush suppresses all errors since it drops every other request.
  always_comb begin
    err_d = err_q;
    if (en) begin
      err_d = 1'b0;
      if (!flush) begin
        if (shift_en && wr_en) begin
          err_d = 1'b1;
        end
        if (!shift_en && wr_en && !wr_hit) begin
          err_d = 1'b1;
        end
        if (!rd_hit0 || !rd_hit1) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Population count of the next valid vector
  always_comb begin
    valid_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_cnt_d = valid_cnt_d + {{AW{1'b0}}, valid_d[i]};
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q     <= '0;
      rd_data0_q  <= '0;
      rd_data1_q  <= '0;
      shift_out_q <= '0;
      valid_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      valid_q     <= valid_d;
      rd_data0_q  <= rd_data0_d;
      rd_data1_q  <= rd_data1_d;
      shift_out_q <= shift_out_d;
      valid_cnt_q <= valid_cnt_d;
      err_q       <= err_d;
    end
  end

  assign rd_data0  = rd_data0_q;
  assign rd_data1  = rd_data1_q;
  assign shift_out = shift_out_q;
  assign valid_vec = valid_q;
  assign valid_cnt = valid_cnt_q;
  assign err       = err_q;

endmodule
`default_nettype wire
